pcie_tx_arbiter: RTL and testbench
==================================

Name: pcie_tx_arbiter

Overview:
- Shares the single 16-bit PCIe TLP transmit port (tx_req/tx_rdy/tx_st/tx_end/tx_data) of the endpoint core between two TLP sources inside ethpipe_mid.
- Requester 0 is the completion generator for BAR reads; requester 1 is the DMA/packet write engine.
- Arbitration is packet-granular: the winner owns the port from its tx_st word through its tx_end word.
- The block also keeps per-requester packet counters and sticky protocol-error flags for status registers.

Parameters:
- PRIO0, 1: 1 = requester 0 has strict priority; 0 = round-robin between the two requesters.
- MAX_LEN, 12'd1024: word-count limit per packet; reaching it without an end word sets err_len.

Ports:
- clk_125  in  1  system clock, 125 MHz
- sys_rst  in  1  synchronous, active-high reset
- reqN_req  in  1  requester N has a TLP pending (N = 0, 1)
- reqN_st  in  1  requester N current word is the first word
- reqN_end  in  1  requester N current word is the last word
- reqN_data  in  16  requester N current word
- reqN_gnt  out  1  requester N owns the port
- reqN_rdy  out  1  requester N word accepted this cycle; requester advances
- tx_req  out  1  to core: transmit request
- tx_rdy  in  1  from core: word accepted this cycle
- tx_st  out  1  to core: first word
- tx_end  out  1  to core: last word
- tx_data  out  16  to core: data word
- pkt_cnt0  out  16  completed packets from requester 0; wraps at 16'hFFFF->0
- pkt_cnt1  out  16  completed packets from requester 1; wraps
- err_proto  out  1  sticky: st seen mid-packet, or first word lacks st
- err_len  out  1  sticky: MAX_LEN words sent without end

Behaviour:
- Reset (sys_rst=1 at clock edge): state=IDLE, rr pointer=0, all gnt/rdy/tx_* outputs 0, counters 0, error flags 0. Reset mid-packet abandons the packet immediately; no tx_end is emitted.
- FSM states: IDLE, REQ, SEND (registered).
- IDLE:
  - If any reqN_req=1, select a winner and register grant. Go to REQ with tx_req=1 and reqN_gnt=1 on the next cycle.
  - Selection with PRIO0=1: req0 wins whenever asserted.
  - Selection with PRIO0=0: both requesting -> the requester not served last wins (rr pointer); a single requester wins unconditionally.
- REQ:
  - tx_req=1. tx_st/tx_end/tx_data are combinational pass-through of the granted requester's st/end/data.
  - reqN_rdy = tx_rdy for the granted requester, 0 for the other.
  - When tx_rdy=1: the first word transfers. If its st=0, set err_proto. tx_req goes 0 from the next cycle.
  - Next state: IDLE if end=1 (single-word packet), else SEND.
- SEND:
  - Same pass-through as REQ; tx_req=0. Each cycle with tx_rdy=1 transfers one word and increments the word counter.
  - st=1 on a transferred word sets err_proto; the word still passes through.
  - Transferred word with end=1: increment pkt_cntN, update rr pointer to N, drop gnt, go to IDLE.
- Outside REQ/SEND: tx_st, tx_end, tx_data are forced to 0 and all reqN_rdy are 0.
- Minimum of one IDLE cycle between packets, so back-to-back packets from the same requester are not merged.
- Word counter: 12 bits, cleared on entry to REQ, saturates at MAX_LEN. Reaching MAX_LEN sets err_len, but the packet continues until its end word (no forced termination).
- A requester dropping reqN_req after grant is ignored; the packet must complete.
- Error flags clear only on reset.

Test Plan:
- Single 4-word packet from req0 (data 0x0001..0x0004, st on first, end on last), tx_rdy=1 throughout -> tx_req high exactly 1 cycle; tx_data 0x0001..0x0004; req0_rdy high 4 cycles; pkt_cnt0=1.
- PRIO0=0, both requesting 3-word packets continuously -> order req0, req1, req0, req1; each packet separated by one or more IDLE cycles; after 4 packets pkt_cnt0=2 and pkt_cnt1=2.
- PRIO0=1, req0 and req1 both requesting -> req0 serviced first; req1 granted only in a cycle when req0_req=0.
- tx_rdy toggling 1,0,1,0 during a 4-word packet -> each word held until accepted; req1_rdy mirrors tx_rdy; no words lost or duplicated.
- Protocol errors: st=1 on the 2nd word -> err_proto=1 and sticky. Separately, MAX_LEN=8 with a 10-word packet -> err_len=1 and all 10 words still delivered.
- Reset asserted on the 2nd word of a packet -> next cycle tx_req=tx_st=tx_end=0, tx_data=0, gnt=0, counters=0; a new packet afterwards transmits normally.

Source files
------------

// File: rtl/pcie_tx_arbiter_if.sv
// Purpose: handshake/data bundle between two TLP requesters, the TX arbiter and the core TX port.
// Latency: none (wires only).
// Backpressure: carries tx_rdy from the core and the per-requester rdy/gnt back to the sources.
//
// Ports (signals):
//   reqN_req/st/end/data : requester N pending flag, first/last word marks, 16-bit word
//   reqN_gnt/rdy         : requester N owns the port / its word was accepted this cycle
//   tx_req/st/end/data   : toward the endpoint core
//   tx_rdy               : core accepted the current word
// Modports: master = arbiter side, slave = requesters and core side.
interface pcie_tx_arbiter_if;
    logic        req0_req;
    logic        req0_st;
    logic        req0_end;
    logic [15:0] req0_data;
    logic        req0_gnt;
    logic        req0_rdy;

    logic        req1_req;
    logic        req1_st;
    logic        req1_end;
    logic [15:0] req1_data;
    logic        req1_gnt;
    logic        req1_rdy;

    logic        tx_req;
    logic        tx_rdy;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;

    modport master (
        input  req0_req, req0_st, req0_end, req0_data,
        input  req1_req, req1_st, req1_end, req1_data,
        output req0_gnt, req0_rdy, req1_gnt, req1_rdy,
        output tx_req, tx_st, tx_end, tx_data,
        input  tx_rdy
    );

    modport slave (
        output req0_req, req0_st, req0_end, req0_data,
        output req1_req, req1_st, req1_end, req1_data,
        input  req0_gnt, req0_rdy, req1_gnt, req1_rdy,
        input  tx_req, tx_st, tx_end, tx_data,
        output tx_rdy
    );
endinterface

// File: rtl/pcie_tx_arbiter.sv
// Purpose: packet-granular arbiter sharing the 16-bit PCIe TLP TX port between two sources.
// Latency: grant registered one cycle after a request in IDLE; data path is combinational pass-through.
// Backpressure: tx_rdy from the core is mirrored onto the granted requester's rdy; words hold until accepted.
//
// Ports:
//   clk_125, sys_rst     : 125 MHz clock, synchronous active-high reset
//   bus (master)         : requester handshakes and core TX port, see pcie_tx_arbiter_if
//   pkt_cnt0, pkt_cnt1   : wrapping completed-packet counters per requester
//   err_proto, err_len   : sticky protocol / over-length error flags
module pcie_tx_arbiter #(
    parameter bit          PRIO0   = 1'b1,
    parameter logic [11:0] MAX_LEN = 12'd1024
) (
    input  logic              clk_125,
    input  logic              sys_rst,
    pcie_tx_arbiter_if.master bus,
    output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1,
    output logic              err_proto,
    output logic              err_len
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        sel_q;        // granted requester
    logic        sel_d;
    logic        rr_q;         // requester that completed the most recent packet
    logic [11:0] word_cnt_q;   // words transferred in the current packet, saturating
    logic [12:0] cnt_next;

    logic        active;
    logic        xfer;
    logic        pick;
    logic        cur_st;
    logic        cur_end;
    logic [15:0] cur_data;

    assign cnt_next = {1'b0, word_cnt_q} + 13'd1;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cur_st   = sel_q ? bus.req1_st   : bus.req0_st;
        cur_end  = sel_q ? bus.req1_end  : bus.req0_end;
        cur_data = sel_q ? bus.req1_data : bus.req0_data;
        active   = (state_q != IDLE);
        xfer     = active && bus.tx_rdy;

        // Contention: strict priority favours req0, otherwise the one not served last.
        if (bus.req0_req && bus.req1_req) begin
            pick = PRIO0 ? 1'b0 : ~rr_q;
        end else begin
            pick = bus.req1_req;
        end

        case (state_q)
            IDLE: begin
                if (bus.req0_req || bus.req1_req) begin
                    sel_d   = pick;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.tx_rdy) begin
                    state_d = cur_end ? IDLE : SEND;
                end
            end
            SEND: begin
                if (bus.tx_rdy && cur_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outside a grant everything toward the core and the requesters is held at zero.
    assign bus.tx_req   = (state_q == REQ);
    assign bus.tx_st    = active && cur_st;
    assign bus.tx_end   = active && cur_end;
    assign bus.tx_data  = active ? cur_data : 16'h0000;
    assign bus.req0_gnt = active && !sel_q;
    assign bus.req1_gnt = active && sel_q;
    assign bus.req0_rdy = xfer && !sel_q;
    assign bus.req1_rdy = xfer && sel_q;

    always_ff @(posedge clk_125) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            rr_q       <= 1'b0;
            word_cnt_q <= 12'd0;
            pkt_cnt0   <= 16'd0;
            pkt_cnt1   <= 16'd0;
            err_proto  <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;

            // Held at zero while idle, so every packet starts counting from zero in REQ.
            if (state_q == IDLE) begin
                word_cnt_q <= 12'd0;
            end else if (xfer && (word_cnt_q != MAX_LEN)) begin
                word_cnt_q <= cnt_next[11:0];
            end

            if (xfer) begin
                if ((state_q == REQ) && !cur_st) begin
                    err_proto <= 1'b1;
                end
                if ((state_q == SEND) && cur_st) begin
                    err_proto <= 1'b1;
                end
                // The first word counts too: MAX_LEN words gone with none marked end.
                if (!cur_end && (cnt_next >= {1'b0, MAX_LEN})) begin
                    err_len <= 1'b1;
                end
                if (cur_end) begin
                    rr_q <= sel_q;
                    if (sel_q) begin
                        pkt_cnt1 <= pkt_cnt1 + 16'd1;
                    end else begin
                        pkt_cnt0 <= pkt_cnt0 + 16'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
`timescale 1ns/1ps
// Two arbiters side by side: index 0 uses strict priority with MAX_LEN 8,
// index 1 uses round-robin with MAX_LEN 1024. Requesters are modelled as
// word queues; a packet-level reference model predicts winners, word order,
// counters and error flags.
module tb_pcie_tx_arbiter;

    typedef struct packed {
        logic        st;
        logic        en;
        logic [15:0] data;
    } word_t;

    logic clk_125 = 1'b0;
    logic sys_rst = 1'b1;
    always #4 clk_125 = ~clk_125;

    pcie_tx_arbiter_if ifa ();
    pcie_tx_arbiter_if ifb ();

    logic        drv_req   [2][2];
    logic        drv_st    [2][2];
    logic        drv_end   [2][2];
    logic [15:0] drv_data  [2][2];
    logic        drv_txrdy [2];

    logic        ob_gnt   [2][2];
    logic        ob_rdy   [2][2];
    logic        ob_txreq [2];
    logic        ob_st    [2];
    logic        ob_end   [2];
    logic [15:0] ob_data  [2];
    logic [15:0] ob_cnt   [2][2];
    logic        ob_errp  [2];
    logic        ob_errl  [2];

    assign ifa.req0_req = drv_req[0][0];  assign ifa.req1_req = drv_req[0][1];
    assign ifa.req0_st  = drv_st[0][0];   assign ifa.req1_st  = drv_st[0][1];
    assign ifa.req0_end = drv_end[0][0];  assign ifa.req1_end = drv_end[0][1];
    assign ifa.req0_data = drv_data[0][0]; assign ifa.req1_data = drv_data[0][1];
    assign ifa.tx_rdy   = drv_txrdy[0];
    assign ifb.req0_req = drv_req[1][0];  assign ifb.req1_req = drv_req[1][1];
    assign ifb.req0_st  = drv_st[1][0];   assign ifb.req1_st  = drv_st[1][1];
    assign ifb.req0_end = drv_end[1][0];  assign ifb.req1_end = drv_end[1][1];
    assign ifb.req0_data = drv_data[1][0]; assign ifb.req1_data = drv_data[1][1];
    assign ifb.tx_rdy   = drv_txrdy[1];

    assign ob_gnt[0][0] = ifa.req0_gnt;  assign ob_gnt[0][1] = ifa.req1_gnt;
    assign ob_rdy[0][0] = ifa.req0_rdy;  assign ob_rdy[0][1] = ifa.req1_rdy;
    assign ob_txreq[0]  = ifa.tx_req;    assign ob_st[0] = ifa.tx_st;
    assign ob_end[0]    = ifa.tx_end;    assign ob_data[0] = ifa.tx_data;
    assign ob_gnt[1][0] = ifb.req0_gnt;  assign ob_gnt[1][1] = ifb.req1_gnt;
    assign ob_rdy[1][0] = ifb.req0_rdy;  assign ob_rdy[1][1] = ifb.req1_rdy;
    assign ob_txreq[1]  = ifb.tx_req;    assign ob_st[1] = ifb.tx_st;
    assign ob_end[1]    = ifb.tx_end;    assign ob_data[1] = ifb.tx_data;

    pcie_tx_arbiter #(.PRIO0(1'b1), .MAX_LEN(12'd8)) dut_p (
        .clk_125   (clk_125),
        .sys_rst   (sys_rst),
        .bus       (ifa),
        .pkt_cnt0  (ob_cnt[0][0]),
        .pkt_cnt1  (ob_cnt[0][1]),
        .err_proto (ob_errp[0]),
        .err_len   (ob_errl[0])
    );

    pcie_tx_arbiter #(.PRIO0(1'b0), .MAX_LEN(12'd1024)) dut_r (
        .clk_125   (clk_125),
        .sys_rst   (sys_rst),
        .bus       (ifb),
        .pkt_cnt0  (ob_cnt[1][0]),
        .pkt_cnt1  (ob_cnt[1][1]),
        .err_proto (ob_errp[1]),
        .err_len   (ob_errl[1])
    );

    // Requester word queues (consumed on rdy) and expected word queues (consumed on transfer).
    word_t wq [4][$];
    word_t eq [4][$];

    // tx_rdy pattern per arbiter: 0 always ready, 1 toggling, 2 random.
    int txmode [2] = '{0, 0};
    logic tgl [2] = '{1'b0, 1'b0};

    // Reference model state.
    int          ls [2];
    logic [15:0] pkt_exp [2][2];
    logic        errp_exp [2];
    logic        errl_exp [2];
    int          wcnt [2];
    logic        prev_req [2][2];
    logic        prev_gnt_any [2];
    logic        prev_end_xfer [2];
    logic        cap_rdy [2][2];
    int          order_q [2][$];
    int          txreq_cyc [2];
    int          rdy_cyc [2][2];
    int          xfer_tot [2];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int maxl(input int d);
        return (d == 0) ? 8 : 1024;
    endfunction

    function automatic void clear_model();
        for (int d = 0; d < 2; d++) begin
            ls[d] = 0;
            errp_exp[d] = 1'b0;
            errl_exp[d] = 1'b0;
            wcnt[d] = 0;
            prev_gnt_any[d] = 1'b0;
            prev_end_xfer[d] = 1'b0;
            for (int r = 0; r < 2; r++) pkt_exp[d][r] = 16'd0;
        end
    endfunction

    // Requester driver and monitor/reference model.
    initial begin : bfm
        logic  any_gnt;
        int    r, k, exp_w;
        word_t e;
        for (int d = 0; d < 2; d++) begin
            drv_txrdy[d] = 1'b0;
            txreq_cyc[d] = 0;
            xfer_tot[d] = 0;
            for (int j = 0; j < 2; j++) begin
                drv_req[d][j] = 1'b0; drv_st[d][j] = 1'b0; drv_end[d][j] = 1'b0;
                drv_data[d][j] = 16'h0; prev_req[d][j] = 1'b0; cap_rdy[d][j] = 1'b0;
                rdy_cyc[d][j] = 0;
            end
        end
        clear_model();
        forever begin
            @(negedge clk_125);
            for (int d = 0; d < 2; d++) begin
                any_gnt = ob_gnt[d][0] | ob_gnt[d][1];
                r = ob_gnt[d][1] ? 1 : 0;
                check($sformatf("rdy0_mirror[%0d]", d), ob_rdy[d][0], ob_gnt[d][0] & drv_txrdy[d]);
                check($sformatf("rdy1_mirror[%0d]", d), ob_rdy[d][1], ob_gnt[d][1] & drv_txrdy[d]);
                check($sformatf("single_gnt[%0d]", d), ob_gnt[d][0] & ob_gnt[d][1], 0);
                if (!any_gnt)
                    check($sformatf("idle_outputs[%0d]", d), {ob_txreq[d], ob_st[d], ob_end[d], ob_data[d]}, 0);
                if (prev_end_xfer[d])
                    check($sformatf("idle_gap[%0d]", d), any_gnt, 0);
                if (any_gnt && !prev_gnt_any[d]) begin
                    // Winner from the request lines present at the granting edge.
                    if (d == 0 || !(prev_req[d][0] && prev_req[d][1]))
                        exp_w = prev_req[d][0] ? 0 : 1;
                    else
                        exp_w = 1 - ls[d];
                    check($sformatf("winner[%0d]", d), r, exp_w);
                    check($sformatf("txreq_on_grant[%0d]", d), ob_txreq[d], 1);
                    order_q[d].push_back(r);
                    wcnt[d] = 0;
                end
                if (ob_txreq[d]) txreq_cyc[d]++;
                for (int j = 0; j < 2; j++) begin
                    if (ob_rdy[d][j]) rdy_cyc[d][j]++;
                    cap_rdy[d][j] = ob_rdy[d][j];
                end
                prev_end_xfer[d] = 1'b0;
                if (any_gnt && drv_txrdy[d]) begin
                    k = 2 * d + r;
                    e = '0;
                    check($sformatf("word_pending[%0d]", d), eq[k].size() > 0, 1);
                    if (eq[k].size() > 0) e = eq[k].pop_front();
                    check($sformatf("word[%0d.%0d]", d, r), {ob_st[d], ob_end[d], ob_data[d]}, e);
                    wcnt[d]++;
                    xfer_tot[d]++;
                    if ((wcnt[d] == 1) != e.st) errp_exp[d] = 1'b1;
                    if (!e.en && wcnt[d] >= maxl(d)) errl_exp[d] = 1'b1;
                    if (e.en) begin
                        pkt_exp[d][r] = pkt_exp[d][r] + 16'd1;
                        ls[d] = r;
                        prev_end_xfer[d] = 1'b1;
                    end
                end
                prev_gnt_any[d] = any_gnt;
                for (int j = 0; j < 2; j++) prev_req[d][j] = drv_req[d][j];
            end
            if (sys_rst) clear_model();

            @(posedge clk_125);
            #1;
            for (int q = 0; q < 4; q++) begin
                if (cap_rdy[q / 2][q % 2] && wq[q].size() > 0) void'(wq[q].pop_front());
                if (!sys_rst && wq[q].size() > 0) begin
                    drv_req[q / 2][q % 2]  = 1'b1;
                    drv_st[q / 2][q % 2]   = wq[q][0].st;
                    drv_end[q / 2][q % 2]  = wq[q][0].en;
                    drv_data[q / 2][q % 2] = wq[q][0].data;
                end else begin
                    drv_req[q / 2][q % 2]  = 1'b0;
                    drv_st[q / 2][q % 2]   = 1'b0;
                    drv_end[q / 2][q % 2]  = 1'b0;
                    drv_data[q / 2][q % 2] = 16'h0;
                end
            end
            for (int d = 0; d < 2; d++) begin
                tgl[d] = ~tgl[d];
                case (txmode[d])
                    1:       drv_txrdy[d] = tgl[d];
                    2:       drv_txrdy[d] = ($urandom_range(0, 3) != 0);
                    default: drv_txrdy[d] = 1'b1;
                endcase
            end
        end
    end

    task automatic push_pkt(input int d, input int r, input int len, input int base, input bit bad_st2);
        word_t w;
        for (int i = 0; i < len; i++) begin
            w.st   = (i == 0) || (bad_st2 && i == 1);
            w.en   = (i == len - 1);
            w.data = (base != 0) ? 16'(base + i) : 16'($urandom_range(0, 65535));
            wq[2 * d + r].push_back(w);
            eq[2 * d + r].push_back(w);
        end
    endtask

    task automatic wait_done(input int d, input int budget);
        int n = 0;
        do begin
            @(posedge clk_125);
            #2;
            n++;
        end while (n < budget && !(wq[2 * d].size() == 0 && wq[2 * d + 1].size() == 0 &&
                                   !ob_gnt[d][0] && !ob_gnt[d][1]));
        check($sformatf("done_in_time[%0d]", d), n < budget, 1);
        check($sformatf("drained[%0d]", d), eq[2 * d].size() + eq[2 * d + 1].size(), 0);
    endtask

    task automatic check_model(input int d);
        check($sformatf("pkt_cnt0[%0d]", d), ob_cnt[d][0], pkt_exp[d][0]);
        check($sformatf("pkt_cnt1[%0d]", d), ob_cnt[d][1], pkt_exp[d][1]);
        check($sformatf("err_proto[%0d]", d), ob_errp[d], errp_exp[d]);
        check($sformatf("err_len[%0d]", d), ob_errl[d], errl_exp[d]);
    endtask

    initial begin : main
        int got;
        repeat (3) @(posedge clk_125);
        #2;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_gnt[%0d]", d), {ob_gnt[d][0], ob_gnt[d][1], ob_rdy[d][0], ob_rdy[d][1]}, 0);
            check($sformatf("rst_tx[%0d]", d), {ob_txreq[d], ob_st[d], ob_end[d], ob_data[d]}, 0);
            check($sformatf("rst_cnt[%0d]", d), {ob_cnt[d][0], ob_cnt[d][1]}, 0);
            check($sformatf("rst_err[%0d]", d), {ob_errp[d], ob_errl[d]}, 0);
        end
        sys_rst = 1'b0;

        // Single 4-word packet from req0, core always ready.
        txreq_cyc[0] = 0;
        rdy_cyc[0][0] = 0;
        push_pkt(0, 0, 4, 1, 1'b0);
        wait_done(0, 100);
        check("single_txreq_cycles", txreq_cyc[0], 1);
        check("single_rdy_cycles", rdy_cyc[0][0], 4);
        check("single_pkt_cnt0", ob_cnt[0][0], 16'd1);
        check_model(0);

        // Round-robin: req0 gets a one-cycle head start, then both keep requesting.
        txmode[1] = 2;
        order_q[1].delete();
        push_pkt(1, 0, 3, 0, 1'b0);
        push_pkt(1, 0, 3, 0, 1'b0);
        @(posedge clk_125);
        #2;
        push_pkt(1, 1, 3, 0, 1'b0);
        push_pkt(1, 1, 3, 0, 1'b0);
        wait_done(1, 400);
        check("rr_pkt_count", order_q[1].size(), 4);
        for (int i = 0; i < 4 && i < order_q[1].size(); i++)
            check($sformatf("rr_order_%0d", i), order_q[1][i], i % 2);
        check("rr_pkt_cnt0", ob_cnt[1][0], 16'd2);
        check("rr_pkt_cnt1", ob_cnt[1][1], 16'd2);
        check_model(1);

        // Strict priority: req1 waits until req0 has nothing left.
        txmode[0] = 2;
        order_q[0].delete();
        push_pkt(0, 0, $urandom_range(3, 5), 0, 1'b0);
        push_pkt(0, 0, $urandom_range(3, 5), 0, 1'b0);
        push_pkt(0, 1, $urandom_range(3, 5), 0, 1'b0);
        wait_done(0, 400);
        check("prio_pkt_count", order_q[0].size(), 3);
        for (int i = 0; i < 3 && i < order_q[0].size(); i++)
            check($sformatf("prio_order_%0d", i), order_q[0][i], (i == 2) ? 1 : 0);
        check("prio_pkt_cnt0", ob_cnt[0][0], 16'd3);
        check_model(0);

        // Toggling tx_rdy on a req1 packet.
        txmode[0] = 1;
        rdy_cyc[0][1] = 0;
        push_pkt(0, 1, 4, 16'h0100, 1'b0);
        wait_done(0, 100);
        check("toggle_rdy_cycles", rdy_cyc[0][1], 4);
        check("toggle_pkt_cnt1", ob_cnt[0][1], 16'd2);

        // st on the second word; flag must stay set across a clean packet.
        txmode[1] = 0;
        push_pkt(1, 0, 4, 0, 1'b1);
        wait_done(1, 100);
        check("proto_err_set", ob_errp[1], 1);
        push_pkt(1, 1, 3, 0, 1'b0);
        wait_done(1, 100);
        check("proto_err_sticky", ob_errp[1], 1);
        check_model(1);

        // 10-word packet against MAX_LEN 8.
        txmode[0] = 0;
        xfer_tot[0] = 0;
        push_pkt(0, 0, 10, 0, 1'b0);
        wait_done(0, 100);
        check("len_err_set", ob_errl[0], 1);
        check("len_all_words", xfer_tot[0], 10);
        check("len_no_proto", ob_errp[0], 0);
        check_model(0);

        // Random traffic on both arbiters.
        for (int i = 0; i < 12; i++) begin
            txmode[0] = $urandom_range(0, 2);
            txmode[1] = $urandom_range(0, 2);
            for (int d = 0; d < 2; d++) begin
                push_pkt(d, $urandom_range(0, 1), $urandom_range(2, 6), 0, 1'b0);
                push_pkt(d, $urandom_range(0, 1), $urandom_range(2, 6), 0, 1'b0);
            end
            wait_done(0, 300);
            wait_done(1, 300);
            check_model(0);
            check_model(1);
        end

        // Reset while the second word of a packet is on the port.
        txmode[1] = 0;
        xfer_tot[1] = 0;
        push_pkt(1, 1, 4, 0, 1'b0);
        got = 0;
        while (got < 40 && xfer_tot[1] < 1) begin
            @(posedge clk_125);
            #2;
            got++;
        end
        check("rst_mid_reached", xfer_tot[1], 1);
        sys_rst = 1'b1;
        @(posedge clk_125);
        #2;
        check("rst_mid_gnt", {ob_gnt[1][0], ob_gnt[1][1]}, 0);
        check("rst_mid_tx", {ob_txreq[1], ob_st[1], ob_end[1], ob_data[1]}, 0);
        check("rst_mid_cnt", {ob_cnt[1][0], ob_cnt[1][1], ob_cnt[0][0], ob_cnt[0][1]}, 0);
        check("rst_mid_err", {ob_errp[0], ob_errl[0], ob_errp[1], ob_errl[1]}, 0);
        for (int q = 0; q < 4; q++) begin
            wq[q].delete();
            eq[q].delete();
        end
        sys_rst = 1'b0;
        push_pkt(1, 0, 3, 16'h0A00, 1'b0);
        wait_done(1, 100);
        check("post_rst_cnt0", ob_cnt[1][0], 16'd1);
        check("post_rst_cnt1", ob_cnt[1][1], 16'd0);
        check_model(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
